ps2_kbd_decoder: RTL

//  Downstream of ps2_controller: consumes received bytes (valid/rx_data/flags) and decodes
//  PS/2 scan code set 2 into key events (code, extended, break, pause). Events are buffered
//  in a small FIFO with a ready/valid output. Gates reception through the controller's en.

---
 rtl/ps2_kbd_decoder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_decoder.sv
// PS/2 scan-code-set-2 decoder: turns controller bytes into make/break/pause key events
// and queues them in a small first-word-fall-through FIFO with ready/valid output.
module ps2_kbd_decoder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int ERR_W       = 8,
  parameter int FLAGS_W     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic [FLAGS_W-1:0] rx_flags,
  input  logic               tx_active,
  output logic               rx_en,
  output logic               key_valid,
  input  logic               key_ready,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_break,
  output logic               key_pause,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [ERR_W-1:0]   drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       pause;
  } key_ev_t;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  state_t        state, state_nxt;
  logic [2:0]    pause_n, pause_n_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          acc, push, err_inc;
  key_ev_t       ev;

  assign acc = rx_valid & ~tx_active;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pause_n <= '0;
    end else begin
      state   <= state_nxt;
      pause_n <= pause_n_nxt;
    end
  end

  // A byte arriving in the same cycle the timeout expires wins: it clears the counter.
  always_ff @(posedge clk) begin
    if (!rst_n || acc || state == IDLE) tmo_cnt <= '0;
    else                                tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_comb begin
    state_nxt   = state;
    pause_n_nxt = pause_n;
    push        = 1'b0;
    err_inc     = 1'b0;
    ev          = '{code: rx_data, ext: 1'b0, brk: 1'b0, pause: 1'b0};
    if (acc) begin
      if (|rx_flags) begin
        err_inc   = 1'b1;
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: case (rx_data)
            8'hE0: state_nxt = EXT;
            8'hF0: state_nxt = BRK;
            8'hE1: begin state_nxt = PAUSE; pause_n_nxt = 3'd7; end
            8'h00, 8'hFF: err_inc = 1'b1;
            8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hEE: ;
            default: push = 1'b1;
          endcase
          EXT: case (rx_data)
            8'hF0: state_nxt = EXT_BRK;
            8'hE0: ;
            8'hE1: begin err_inc = 1'b1; state_nxt = IDLE; end
            default: begin push = 1'b1; ev.ext = 1'b1; state_nxt = IDLE; end
          endcase
          BRK, EXT_BRK: begin
            state_nxt = IDLE;
            if (rx_data == 8'hE0 || rx_data == 8'hF0 || rx_data == 8'hE1) err_inc = 1'b1;
            else begin
              push   = 1'b1;
              ev.ext = (state == EXT_BRK);
              ev.brk = 1'b1;
            end
          end
          PAUSE: begin
            // Pause sequence content is not validated; only its length matters.
            if (pause_n == 3'd1) begin
              push      = 1'b1;
              ev        = '{code: 8'h77, ext: 1'b0, brk: 1'b0, pause: 1'b1};
              state_nxt = IDLE;
            end else pause_n_nxt = pause_n - 1'b1;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end else if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
      err_inc   = 1'b1;
      state_nxt = IDLE;
    end
  end

  // Event FIFO
  key_ev_t       mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          full, pop, do_push, drop;
  key_ev_t       head;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign key_valid = (count != '0);
  assign pop       = key_valid & key_ready;
  assign do_push   = push & (~full | pop);
  assign drop      = push & full & ~pop;

  always_comb begin
    count_nxt = count;
    case ({do_push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rx_en    <= 1'b0;
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      rx_en <= (count_nxt != CW'(FIFO_DEPTH));
      if (err_inc && err_cnt != '1) err_cnt  <= err_cnt + 1'b1;
      if (drop && drop_cnt != '1)   drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= ev;
  end

  assign head      = key_valid ? mem[rd_ptr] : '0;
  assign key_code  = head.code;
  assign key_ext   = head.ext;
  assign key_break = head.brk;
  assign key_pause = head.pause;

endmodule
